gpr_wb_sched: RTL

- Write-port scheduler and scoreboard for the RV64 general-purpose register file (32 x 64-bit, single write port, same-cycle write-to-read bypass).
- Shares the single write port among three writeback sources (ALU, LSU, MDU) using round-robin valid/ready arbitration.
- Tracks a busy bit per destination register, so decode stalls on RAW and WAW hazards against in-flight writes.
- Sits between decode/issue, the execution units and the register file write port.

---
 rtl/gpr_wb_sched.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gpr_wb_sched.sv
// -----------------------------------------------------------------------------
// gpr_wb_sched
//
// Write-port scheduler and register scoreboard for the RV64 integer register
// file (32 x 64-bit, one write port, write-to-read bypass inside the regfile).
//
// Three writeback sources (ALU, LSU, MDU) share the single write port under
// round-robin arbitration. A busy bit per destination register stalls decode
// on RAW and WAW hazards against writes that are still in flight.
//
// Handshake: a source raises *_valid with *_rd/*_data and must hold all three
// stable until it sees *_ready. The transfer happens in the cycle where
// valid && ready. *_ready is combinational and never depends on issue.
// Decode sees iss_ready combinationally. It does not depend on iss_valid, and
// an instruction issues in the cycle where iss_valid && iss_ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   iss_valid/rs1/rs2/rd/wr    instruction presented by decode
//   iss_ready                  no hazard; the issue is accepted
//   {alu,lsu,mdu}_valid/rd/data writeback requests
//   {alu,lsu,mdu}_ready        grant (at most one per cycle)
//   rf_wen/rf_waddr/rf_wdata   registered register-file write port
//   busy_o                     scoreboard bits (bit 0 always 0)
//   err_o                      sticky: a write hit a register that was not busy
//   dbg_rr_ptr_o               round-robin pointer (0=ALU, 1=LSU, 2=MDU)
// -----------------------------------------------------------------------------
module gpr_wb_sched #(
  parameter int WIDTH     = 64,
  parameter int REG_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // issue side
  input  logic                        iss_valid,
  input  logic [REG_WIDTH-1:0]        iss_rs1,
  input  logic [REG_WIDTH-1:0]        iss_rs2,
  input  logic [REG_WIDTH-1:0]        iss_rd,
  input  logic                        iss_wr,
  output logic                        iss_ready,
  // ALU writeback
  input  logic                        alu_valid,
  input  logic [REG_WIDTH-1:0]        alu_rd,
  input  logic [WIDTH-1:0]            alu_data,
  output logic                        alu_ready,
  // LSU writeback
  input  logic                        lsu_valid,
  input  logic [REG_WIDTH-1:0]        lsu_rd,
  input  logic [WIDTH-1:0]            lsu_data,
  output logic                        lsu_ready,
  // MDU writeback
  input  logic                        mdu_valid,
  input  logic [REG_WIDTH-1:0]        mdu_rd,
  input  logic [WIDTH-1:0]            mdu_data,
  output logic                        mdu_ready,
  // register file write port
  output logic                        rf_wen,
  output logic [REG_WIDTH-1:0]        rf_waddr,
  output logic [WIDTH-1:0]            rf_wdata,
  // status
  output logic [(2**REG_WIDTH)-1:0]   busy_o,
  output logic                        err_o,
  output logic [1:0]                  dbg_rr_ptr_o
);

  localparam int NREGS = 2 ** REG_WIDTH;

  // Round-robin pointer: the source that has highest priority this cycle.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MDU = 2'd2
  } src_e;

  src_e                 rr_q, rr_d;
  logic                 rf_wen_q, rf_wen_d;
  logic [REG_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]     busy_q, busy_d;
  logic                 err_q, err_d;

  // arbitration results
  logic                 gnt_vld;
  src_e                 gnt_src;
  logic [2:0]           gnt_vec;
  logic [REG_WIDTH-1:0] gnt_rd;
  logic [WIDTH-1:0]     gnt_data;

  // scoreboard helpers
  logic [NREGS-1:0]     wb_clr;
  logic [NREGS-1:0]     eff_busy;
  logic                 iss_fire;

  // ---------------------------------------------------------------------------
  // Arbitration: search starts at the pointer and wraps ALU->LSU->MDU->ALU.
  // The pointer moves to the source after the winner, and only on a grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_ALU;
    case (rr_q)
      SRC_LSU: begin
        if (lsu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_LSU;
        end else if (mdu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_MDU;
        end else if (alu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_ALU;
        end
      end
      SRC_MDU: begin
        if (mdu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_MDU;
        end else if (alu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_ALU;
        end else if (lsu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_LSU;
        end
      end
      default: begin
        if (alu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_ALU;
        end else if (lsu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_LSU;
        end else if (mdu_valid) begin
          gnt_vld = 1'b1; gnt_src = SRC_MDU;
        end
      end
    endcase
  end

  always_comb begin
    gnt_vec  = 3'b000;
    gnt_rd   = alu_rd;
    gnt_data = alu_data;
    rr_d     = rr_q;
    if (gnt_vld) begin
      case (gnt_src)
        SRC_LSU: begin
          gnt_vec  = 3'b010;
          gnt_rd   = lsu_rd;
          gnt_data = lsu_data;
          rr_d     = SRC_MDU;
        end
        SRC_MDU: begin
          gnt_vec  = 3'b100;
          gnt_rd   = mdu_rd;
          gnt_data = mdu_data;
          rr_d     = SRC_ALU;
        end
        default: begin
          gnt_vec  = 3'b001;
          gnt_rd   = alu_rd;
          gnt_data = alu_data;
          rr_d     = SRC_LSU;
        end
      endcase
    end
  end

  assign alu_ready = gnt_vec[0];
  assign lsu_ready = gnt_vec[1];
  assign mdu_ready = gnt_vec[2];

  // ---------------------------------------------------------------------------
  // Write port. A granted write to x0 is consumed but never reaches the
  // regfile; address and data only move when a real write is launched.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_wen_d   = gnt_vld && (gnt_rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_wen_d) begin
      rf_waddr_d = gnt_rd;
      rf_wdata_d = gnt_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard. The write currently on the port clears its busy bit at the
  // end of this cycle, and the regfile bypass already supplies its data, so
  // it no longer counts as a hazard this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_clr = '0;
    for (int i = 0; i < NREGS; i++) begin
      wb_clr[i] = rf_wen_q && (rf_waddr_q == REG_WIDTH'(i));
    end
  end

  always_comb begin
    eff_busy    = busy_q & ~wb_clr;
    eff_busy[0] = 1'b0;
  end

  assign iss_ready = !(eff_busy[iss_rs1] || eff_busy[iss_rs2] ||
                       (iss_wr && eff_busy[iss_rd]));

  assign iss_fire = iss_valid && iss_ready && iss_wr && (iss_rd != '0);

  // Clear first, then set: a new producer for the same register wins.
  always_comb begin
    busy_d = busy_q & ~wb_clr;
    if (iss_fire) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // A write landing on a register with no outstanding producer is a protocol
  // error upstream; it is remembered until reset.
  always_comb begin
    err_d = err_q;
    if (rf_wen_q && (rf_waddr_q != '0) && !busy_q[rf_waddr_q]) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= SRC_ALU;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign dbg_rr_ptr_o = rr_q;

endmodule
